// File: rtl/sal_ref_ctrl.sv
// All-bank auto-refresh scheduler: keeps tREFI, counts owed refreshes, postpones
// until banks idle (bounded by MAX_POSTPONE), then drains banks, issues REF and holds tRFC.
module sal_ref_ctrl #(
  parameter int BK_CNT       = 8,
  parameter int TREFI_W      = 16,
  parameter int TRFC_W       = 8,
  parameter int MAX_POSTPONE = 8,
  localparam int OWED_W      = $clog2(MAX_POSTPONE + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_ref_en,
  input  logic [TREFI_W-1:0] cfg_trefi,
  input  logic [TRFC_W-1:0]  cfg_trfc,
  input  logic [BK_CNT-1:0]  bk_idle_i,
  input  logic [BK_CNT-1:0]  pb_ref_gnt_i,
  output logic [BK_CNT-1:0]  pb_ref_req_o,
  output logic               ref_cmd_req_o,
  input  logic               ref_cmd_gnt_i,
  output logic               ref_busy_o,
  output logic [OWED_W-1:0]  ref_owed_o,
  output logic               ref_urgent_o,
  output logic               ref_err_o,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_ISSUE = 2'd2,
    S_RFC   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [TREFI_W-1:0]  itv;
  logic [TRFC_W-1:0]   rfc;
  logic [OWED_W-1:0]   owed;
  logic                err;
  logic                tick;
  logic                gnt_acc;
  logic                owed_full;
  logic                all_idle;

  // Handshakes: pb_ref_req is held until every bank answers with pb_ref_gnt (level,
  // all bits ANDed); ref_cmd_req is held in ISSUE and a single-cycle ref_cmd_gnt
  // there is the transfer. Grants seen while not requesting are ignored.
  assign tick      = cfg_ref_en && (itv == cfg_trefi - TREFI_W'(1));
  assign gnt_acc   = (state == S_ISSUE) && ref_cmd_gnt_i;
  assign owed_full = (owed == OWED_W'(MAX_POSTPONE));
  assign all_idle  = &bk_idle_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      itv <= '0;
    end else if (!cfg_ref_en || tick) begin
      itv <= '0;
    end else begin
      itv <= itv + TREFI_W'(1);
    end
  end

  // A tick and an accepted grant in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owed <= '0;
      err  <= 1'b0;
    end else if (tick && !gnt_acc) begin
      if (owed_full) err <= 1'b1;
      else           owed <= owed + OWED_W'(1);
    end else if (!tick && gnt_acc) begin
      owed <= owed - OWED_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rfc <= '0;
    end else if (gnt_acc) begin
      rfc <= cfg_trfc - TRFC_W'(1);
    end else if (state == S_RFC && rfc != '0) begin
      rfc <= rfc - TRFC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cfg_ref_en && owed != '0 && (all_idle || owed_full)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (&pb_ref_gnt_i) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (ref_cmd_gnt_i) state_nxt = S_RFC;
      end
      S_RFC: begin
        // Back-to-back pull-in keeps the banks held; disabling refresh suppresses it.
        if (rfc == '0) begin
          if (cfg_ref_en && owed != '0 && all_idle) state_nxt = S_ISSUE;
          else                                      state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pb_ref_req_o  = {BK_CNT{state != S_IDLE}};
  assign ref_cmd_req_o = (state == S_ISSUE);
  assign ref_busy_o    = (state == S_RFC);
  assign ref_owed_o    = owed;
  assign ref_urgent_o  = owed_full;
  assign ref_err_o     = err;
  assign dbg_state     = state;

endmodule

// File: tb/tb_sal_ref_ctrl.sv
// Directed bench for sal_ref_ctrl: bank/scheduler responders plus cycle-exact
// hand-computed expectations for refresh, postponement, pull-in, overflow, reset, disable.
module tb_sal_ref_ctrl;

  localparam int BK = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_ref_en;
  logic [15:0] cfg_trefi;
  logic [7:0]  cfg_trfc;
  logic [BK-1:0] bk_idle_i;
  logic [BK-1:0] pb_ref_gnt_i;
  logic [BK-1:0] pb_ref_req_o;
  logic        ref_cmd_req_o;
  logic        ref_cmd_gnt_i;
  logic        ref_busy_o;
  logic [3:0]  ref_owed_o;
  logic        ref_urgent_o;
  logic        ref_err_o;
  logic [1:0]  dbg_state;

  sal_ref_ctrl dut (
    .clk(clk), .rst(rst), .cfg_ref_en(cfg_ref_en), .cfg_trefi(cfg_trefi),
    .cfg_trfc(cfg_trfc), .bk_idle_i(bk_idle_i), .pb_ref_gnt_i(pb_ref_gnt_i),
    .pb_ref_req_o(pb_ref_req_o), .ref_cmd_req_o(ref_cmd_req_o),
    .ref_cmd_gnt_i(ref_cmd_gnt_i), .ref_busy_o(ref_busy_o), .ref_owed_o(ref_owed_o),
    .ref_urgent_o(ref_urgent_o), .ref_err_o(ref_err_o), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cmd_mode = 0;   // 0: no scheduler grant, 1: same-cycle grant, 2: grant one cycle later
  logic [2:0] gh;
  logic creq_prev;
  int   e0;
  int   n;
  int   bad;
  int   r0, r1, r2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: outputs sampled at negedge, responder inputs driven for that same cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    pb_ref_gnt_i = {BK{gh[2]}};
    gh = {gh[1:0], pb_ref_req_o[0]};
    case (cmd_mode)
      1:       ref_cmd_gnt_i = ref_cmd_req_o;
      2:       ref_cmd_gnt_i = creq_prev;
      default: ref_cmd_gnt_i = 1'b0;
    endcase
    creq_prev = ref_cmd_req_o;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_ref_en = 1'b0;
    gh = '0;
    creq_prev = 1'b0;
    pb_ref_gnt_i = '0;
    ref_cmd_gnt_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic start(input int trefi, input int trfc, input logic idle, input int mode);
    cfg_trefi = 16'(trefi);
    cfg_trfc  = 8'(trfc);
    bk_idle_i = {BK{idle}};
    cmd_mode  = mode;
    cfg_ref_en = 1'b1;
    e0 = cyc;
  endtask

  task automatic count_busy(output int len);
    len = 0;
    while (ref_busy_o && len < 300) begin
      len++;
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_ref_en = 1'b0;
    cfg_trefi = 16'd100;
    cfg_trfc = 8'd10;
    bk_idle_i = '1;
    pb_ref_gnt_i = '0;
    ref_cmd_gnt_i = 1'b0;
    gh = '0;
    creq_prev = 1'b0;
    #1;
    check("rst_req", 32'(pb_ref_req_o), 0);
    check("rst_owed", 32'(ref_owed_o), 0);
    check("rst_err", 32'(ref_err_o), 0);
    check("rst_state", 32'(dbg_state), 0);

    // Basic refresh: tick at E+99, DRAIN E+101, ISSUE E+105, grant E+106, busy E+107..E+116.
    do_reset();
    start(100, 10, 1'b1, 2);
    run_to(e0 + 100);
    check("bas_owed1", 32'(ref_owed_o), 1);
    check("bas_req_idle", 32'(pb_ref_req_o), 0);
    step();
    check("bas_drain_req", 32'(pb_ref_req_o), 32'hff);
    check("bas_drain_st", 32'(dbg_state), 1);
    run_to(e0 + 105);
    check("bas_cmd_req", 32'(ref_cmd_req_o), 1);
    run_to(e0 + 107);
    check("bas_busy", 32'(ref_busy_o), 1);
    check("bas_owed0", 32'(ref_owed_o), 0);
    count_busy(n);
    check("bas_busy_len", 32'(n), 10);
    check("bas_req_drop", 32'(pb_ref_req_o), 0);
    check("bas_drop_cyc", 32'(cyc - e0), 117);
    run_to(e0 + 206);
    check("bas_pre2_busy", 32'(ref_busy_o), 0);
    step();
    check("bas_ref2_busy", 32'(ref_busy_o), 1);
    check("bas_ref2_owed", 32'(ref_owed_o), 0);

    // Postponement: banks busy, owed k visible at E+10k, DRAIN only once urgent.
    do_reset();
    start(10, 4, 1'b0, 2);
    for (int k = 1; k <= 8; k++) begin
      run_to(e0 + 10 * k);
      check("pp_owed", 32'(ref_owed_o), 32'(k));
      check("pp_urgent", 32'(ref_urgent_o), 32'(k == 8));
      check("pp_no_req", 32'(pb_ref_req_o), 0);
    end
    step();
    check("pp_drain", 32'(dbg_state), 1);
    run_to(e0 + 87);
    check("pp_busy", 32'(ref_busy_o), 1);
    check("pp_owed7", 32'(ref_owed_o), 7);
    check("pp_urg_off", 32'(ref_urgent_o), 0);

    // Pull-in: owed=3 at E+75, banks go idle, grants E+80/E+85/E+90, IDLE at E+95.
    do_reset();
    start(25, 4, 1'b0, 1);
    run_to(e0 + 75);
    check("pi_owed3", 32'(ref_owed_o), 3);
    bk_idle_i = '1;
    r0 = -1; r1 = -1; r2 = -1;
    bad = 0;
    step();
    while (cyc < e0 + 95) begin
      if (pb_ref_req_o != '1) bad++;
      if (ref_busy_o && dbg_state == 2'd3 && r0 < 0) r0 = cyc;
      else if (ref_busy_o && r0 >= 0 && r1 < 0 && cyc > r0 + 4) r1 = cyc;
      else if (ref_busy_o && r1 >= 0 && r2 < 0 && cyc > r1 + 4) r2 = cyc;
      step();
    end
    check("pi_req_held", 32'(bad), 0);
    check("pi_first", 32'(r0 - e0), 81);
    check("pi_gap1", 32'(r1 - r0), 5);
    check("pi_gap2", 32'(r2 - r1), 5);
    check("pi_idle", 32'(dbg_state), 0);
    check("pi_req_drop", 32'(pb_ref_req_o), 0);
    check("pi_owed0", 32'(ref_owed_o), 0);

    // Tick coincident with grant at owed=8: no change, no error.
    do_reset();
    start(10, 4, 1'b0, 0);
    run_to(e0 + 85);
    check("sim_issue", 32'(dbg_state), 2);
    run_to(e0 + 89);
    check("sim_owed8", 32'(ref_owed_o), 8);
    ref_cmd_gnt_i = 1'b1;
    step();
    check("sim_owed_hold", 32'(ref_owed_o), 8);
    check("sim_err0", 32'(ref_err_o), 0);
    check("sim_busy", 32'(ref_busy_o), 1);

    // Overflow: no scheduler grant, 9th tick at E+89 sets the sticky error.
    do_reset();
    start(10, 4, 1'b0, 0);
    run_to(e0 + 89);
    check("ovf_err_pre", 32'(ref_err_o), 0);
    check("ovf_owed_pre", 32'(ref_owed_o), 8);
    step();
    check("ovf_err", 32'(ref_err_o), 1);
    check("ovf_owed_sat", 32'(ref_owed_o), 8);
    run_to(e0 + 120);
    check("ovf_err_sticky", 32'(ref_err_o), 1);
    check("ovf_stuck_issue", 32'(dbg_state), 2);

    // Reset during RFC: async clear within the same cycle.
    do_reset();
    start(10, 8, 1'b1, 2);
    run_to(e0 + 19);
    check("rr_busy", 32'(ref_busy_o), 1);
    rst = 1'b1;
    #1;
    check("rr_req", 32'(pb_ref_req_o), 0);
    check("rr_busy0", 32'(ref_busy_o), 0);
    check("rr_cmd", 32'(ref_cmd_req_o), 0);
    check("rr_owed", 32'(ref_owed_o), 0);
    check("rr_state", 32'(dbg_state), 0);

    // Enable cleared during ISSUE: REF completes, then no further ticks.
    do_reset();
    start(10, 4, 1'b1, 2);
    run_to(e0 + 15);
    check("dis_issue", 32'(dbg_state), 2);
    cfg_ref_en = 1'b0;
    run_to(e0 + 17);
    check("dis_busy", 32'(ref_busy_o), 1);
    count_busy(n);
    check("dis_busy_len", 32'(n), 4);
    check("dis_idle", 32'(dbg_state), 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (pb_ref_req_o != '0 || ref_owed_o != '0) bad++;
    end
    check("dis_quiet", 32'(bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sal_ref_ctrl.md
# sal_ref_ctrl

All-bank auto-refresh scheduler for the DDR2 controller. Keeps the tREFI interval, tracks how many refreshes are owed, and postpones each one until the banks go idle, up to a fixed limit. It then drives the per-bank refresh handshake (`pb_ref_req`/`pb_ref_gnt`) on every bank controller to force all banks precharged, asks the command scheduler to issue a REF, and holds the banks closed for tRFC. It sits beside the bank controllers and the scheduler. Its timing inputs come from the configuration block.

## Interface

Parameters:
- `BK_CNT`, 8: number of DRAM banks.
- `TREFI_W`, 16: width of the tREFI counter and config field.
- `TRFC_W`, 8: width of the tRFC counter and config field.
- `MAX_POSTPONE`, 8: maximum number of owed refreshes. Width of `ref_owed_o` is $clog2(MAX_POSTPONE+1).

Ports:
- `clk` in 1: controller clock. One clock domain only.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_ref_en` in 1: refresh enable.
- `cfg_trefi` in TREFI_W: refresh interval in cycles. Legal values are ≥2.
- `cfg_trfc` in TRFC_W: REF-to-activate time in cycles. Legal values are ≥1.
- `bk_idle_i` in BK_CNT: bank has no queued request.
- `pb_ref_gnt_i` in BK_CNT: bank is precharged and is holding off activates.
- `pb_ref_req_o` out BK_CNT: refresh request to each bank controller. All bits are always equal.
- `ref_cmd_req_o` out 1: request to the scheduler to issue an all-bank REF.
- `ref_cmd_gnt_i` in 1: the scheduler drives REF on DFI this cycle.
- `ref_busy_o` out 1: tRFC window is active.
- `ref_owed_o` out $clog2(MAX_POSTPONE+1): number of refreshes owed.
- `ref_urgent_o` out 1: `ref_owed_o == MAX_POSTPONE`.
- `ref_err_o` out 1: sticky flag. Set when a tick arrives while the owed count is saturated.

## Operation

- **Interval counter `itv`.**
  - Reset value is 0.
  - When `cfg_ref_en` is 1:
    - If `itv == cfg_trefi-1`, produce a tick and set `itv` to 0.
    - Otherwise increment `itv`.
  - When `cfg_ref_en` is 0, hold `itv` at 0. No ticks are produced.
- **Owed count `owed`.**
  - Reset value is 0.
  - A tick increments `owed`.
  - A `ref_cmd_gnt_i` that is accepted in ISSUE decrements `owed`.
  - If both happen in the same cycle, `owed` is unchanged.
  - A tick when `owed == MAX_POSTPONE` with no accepted grant leaves `owed` saturated and sets `ref_err_o`. Only `rst` clears `ref_err_o`.
- **State machine.** Reset state is IDLE.
  - IDLE
    - Outputs `pb_ref_req_o`, `ref_cmd_req_o` and `ref_busy_o` are all 0.
    - Go to DRAIN when `cfg_ref_en` is 1, `owed != 0`, and at least one of these is true: `&bk_idle_i`, or `owed == MAX_POSTPONE`.
  - DRAIN
    - `pb_ref_req_o` is all ones.
    - Go to ISSUE when `&pb_ref_gnt_i` is 1.
  - ISSUE
    - `pb_ref_req_o` is all ones and `ref_cmd_req_o` is 1.
    - When `ref_cmd_gnt_i` is 1: decrement `owed`, load `rfc = cfg_trfc-1`, and go to RFC.
    - A `ref_cmd_gnt_i` seen outside ISSUE is ignored.
  - RFC
    - `pb_ref_req_o` is all ones and `ref_busy_o` is 1.
    - Decrement `rfc` each cycle.
    - When `rfc == 0`, evaluate the exit:
      - If `owed != 0` and `&bk_idle_i` is 1, go back to ISSUE. This is a back-to-back pull-in and the banks stay held.
      - Otherwise go to IDLE.
- **Enable cleared mid-sequence.** If `cfg_ref_en` drops during DRAIN, ISSUE or RFC, the current REF still completes. Pull-in is suppressed, and no new sequence starts.
- **Outputs.**
  - All outputs are Moore outputs, decoded from registered state.
  - `ref_owed_o` and `ref_urgent_o` come from `owed`.
  - Reset values of all outputs are 0.
- **Reset mid-operation.** Asserting `rst` returns the block to IDLE at once. `owed`, `itv`, `rfc` and `ref_err_o` are all cleared. `pb_ref_req_o` drops asynchronously.

## Timing

- **Tick spacing.** With `cfg_trefi = N`, ticks occur every N cycles. The first tick comes N cycles after `cfg_ref_en` rises.
- **Owed update.** A tick in cycle t is visible on `ref_owed_o` in cycle t+1.
- **IDLE to DRAIN.**
  - A qualifying IDLE condition in cycle t puts the block in DRAIN in cycle t+1. `pb_ref_req_o` is high from that cycle.
  - The earliest DRAIN after a tick in cycle t is therefore t+2.
- **Grants to request.** `&pb_ref_gnt_i` in cycle t gives ISSUE in t+1, with `ref_cmd_req_o` high from t+1.
- **tRFC window.**
  - `ref_cmd_gnt_i` in cycle t makes `ref_busy_o` high for exactly `cfg_trfc` cycles, t+1 through t+cfg_trfc.
  - `pb_ref_req_o` drops in cycle t+cfg_trfc+1 unless a pull-in occurs.
  - With a pull-in, `ref_cmd_req_o` rises in t+cfg_trfc+1.
- **Config stability.** `cfg_trefi` and `cfg_trfc` are sampled continuously. Software changes them only while `cfg_ref_en` is 0.

## Test plan

- **Basic refresh.**
  - Stimulus: `cfg_trefi=100`, `cfg_trfc=10`, all banks idle, `pb_ref_gnt_i` follows the request after 3 cycles, `ref_cmd_gnt_i` returns 1 cycle after request.
  - Required: one REF every 100 cycles, `ref_busy_o` high for exactly 10 cycles, `ref_owed_o` returns to 0.
- **Postponement.**
  - Stimulus: `bk_idle_i=0` held.
  - Required: `owed` counts up 1..8, DRAIN starts only when `ref_urgent_o` is 1, and a single REF brings `owed` to 7.
- **Pull-in.**
  - Stimulus: `owed=3` accumulated while busy, then all banks go idle.
  - Required: three back-to-back REFs spaced `cfg_trfc+1` cycles apart, with `pb_ref_req_o` held continuously, then IDLE.
- **Overflow and simultaneous events.**
  - Stimulus: hold `ref_cmd_gnt_i=0` past 9 ticks.
  - Required: `owed` saturates at 8 and `ref_err_o` latches 1.
  - Stimulus: force a tick in the same cycle as a grant at `owed=8`.
  - Required: `owed` stays 8 and `ref_err_o` is not newly set.
- **Reset and disable.**
  - Stimulus: assert `rst` during RFC.
  - Required: all outputs are 0 in the same cycle and the block is in IDLE.
  - Stimulus: clear `cfg_ref_en` during ISSUE.
  - Required: the REF completes, then the block goes to IDLE with no further ticks.
